// File: rtl/vc_pop_arbiter_if.sv
// Pop-scheduler bundle: VC FIFO heads, destination flags,
// pop strobes and the registered demux word.
interface vc_pop_arbiter_if #(
  parameter int DATA_W = 6
) ();
  logic              init;
  logic              VC0_empty;
  logic              VC1_empty;
  logic [DATA_W-1:0] VC0_data_out;
  logic [DATA_W-1:0] VC1_data_out;
  logic              D0_almost_full;
  logic              D1_almost_full;
  logic              VC0_rd;
  logic              VC1_rd;
  logic [DATA_W-1:0] demux_dest_in;
  logic              demux_dest_valid_in;
  logic              idle;
  logic [1:0]        state;

  modport master (
    input  init,
    input  VC0_empty,
    input  VC1_empty,
    input  VC0_data_out,
    input  VC1_data_out,
    input  D0_almost_full,
    input  D1_almost_full,
    output VC0_rd,
    output VC1_rd,
    output demux_dest_in,
    output demux_dest_valid_in,
    output idle,
    output state
  );

  modport slave (
    output init,
    output VC0_empty,
    output VC1_empty,
    output VC0_data_out,
    output VC1_data_out,
    output D0_almost_full,
    output D1_almost_full,
    input  VC0_rd,
    input  VC1_rd,
    input  demux_dest_in,
    input  demux_dest_valid_in,
    input  idle,
    input  state
  );
endinterface

// File: rtl/vc_pop_arbiter.sv
// VC pop scheduler: VC0 strict priority with a VC1 starvation
// guard, blocked on destination almost-full, registered output.
module vc_pop_arbiter #(
  parameter int DATA_W     = 6,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             reset_L,
  vc_pop_arbiter_if.master bus
);
  localparam logic [1:0] ST_RESET  = 2'b00;
  localparam logic [1:0] ST_INIT   = 2'b01;
  localparam logic [1:0] ST_IDLE   = 2'b10;
  localparam logic [1:0] ST_ACTIVE = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(STARVE_MAX);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              idle_q, idle_d;
  logic              run, go, starved;
  logic              grant0, grant1;

  assign run = (state_q == ST_IDLE) ||
               (state_q == ST_ACTIVE);

  // reset_L gates rd so strobes drop the instant reset falls
  assign go = reset_L & run & ~bus.init &
              ~bus.D0_almost_full &
              ~bus.D1_almost_full;

  assign starved = ~bus.VC1_empty & (cnt_q >= CNT_MAX);
  assign grant1  = go & ~bus.VC1_empty &
                   (starved | bus.VC0_empty);
  assign grant0  = go & ~bus.VC0_empty & ~starved;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT:  state_d = bus.init ? ST_INIT : ST_IDLE;
      ST_IDLE: begin
        if (bus.init)
          state_d = ST_INIT;
        else if (!bus.VC0_empty || !bus.VC1_empty)
          state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (bus.init)
          state_d = ST_INIT;
        else if (bus.VC0_empty && bus.VC1_empty)
          state_d = ST_IDLE;
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!run || bus.init || grant1 || bus.VC1_empty)
      cnt_d = '0;
    else if (grant0 && cnt_q < CNT_MAX)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    data_d  = '0;
    valid_d = 1'b0;
    unique case (1'b1)
      grant0: begin
        data_d  = bus.VC0_data_out;
        valid_d = 1'b1;
      end
      grant1: begin
        data_d  = bus.VC1_data_out;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign idle_d = (state_d == ST_IDLE);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      idle_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      idle_q  <= idle_d;
    end
  end

  assign bus.VC0_rd              = grant0;
  assign bus.VC1_rd              = grant1;
  assign bus.demux_dest_in       = data_q;
  assign bus.demux_dest_valid_in = valid_q;
  assign bus.idle                = idle_q;
  assign bus.state               = state_q;
endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Random-stimulus bench: bench-owned VC FIFOs, rule-level
// reference model, scoreboard checked by a separate monitor.
module tb_vc_pop_arbiter;
  localparam int STARVE_MAX = 4;

  typedef struct {
    int         cyc;
    logic [5:0] d;
  } sb_t;

  logic clk = 1'b0;
  logic reset_L;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [5:0] q0[$];
  logic [5:0] q1[$];
  sb_t        sb[$];
  logic [5:0] seq = 6'd1;

  int ms = 0;
  int streak = 0;
  int pend = -1;

  vc_pop_arbiter_if #(.DATA_W(6)) bus ();

  vc_pop_arbiter #(
    .DATA_W(6),
    .STARVE_MAX(STARVE_MAX),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset_L(reset_L),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d",
               n, cyc, act, exp);
    end
  endtask

  task automatic fill(input int n0, input int n1);
    for (int i = 0; i < n0; i++) begin
      q0.push_back(seq);
      seq++;
    end
    for (int i = 0; i < n1; i++) begin
      q1.push_back(seq);
      seq++;
    end
  endtask

  task automatic step(input bit rst_n, input bit i_init,
                      input bit af0, input bit af1,
                      input int push_pct,
                      input bit drop_rst);
    int  g;
    bit  v0, v1, go;
    sb_t e;
    @(posedge clk);
    #2;
    if (pend == 0) void'(q0.pop_front());
    else if (pend == 1) void'(q1.pop_front());
    pend = -1;
    if ($urandom_range(99) < push_pct && q0.size() < 8)
      fill(1, 0);
    if ($urandom_range(99) < push_pct && q1.size() < 8)
      fill(0, 1);
    reset_L = rst_n;
    if (!rst_n) begin
      ms = 0;
      streak = 0;
      sb.delete();
    end
    v0 = q0.size() > 0;
    v1 = q1.size() > 0;
    bus.init           = i_init;
    bus.D0_almost_full = af0;
    bus.D1_almost_full = af1;
    bus.VC0_empty      = !v0;
    bus.VC1_empty      = !v1;
    bus.VC0_data_out   = v0 ? q0[0] : 6'd0;
    bus.VC1_data_out   = v1 ? q1[0] : 6'd0;
    #1;
    chk("state", int'(bus.state), ms);
    chk("idle", int'(bus.idle), int'(ms == 2));
    go = rst_n && ms >= 2 && !i_init && !af0 && !af1;
    g = -1;
    if (go && v1 && streak >= STARVE_MAX) g = 1;
    else if (go && v0) g = 0;
    else if (go && v1) g = 1;
    chk("VC0_rd", int'(bus.VC0_rd), int'(g == 0));
    chk("VC1_rd", int'(bus.VC1_rd), int'(g == 1));
    if (drop_rst) begin
      chk("drop_needs_vc1", g, 1);
      #1;
      reset_L = 1'b0;
      sb.delete();
      ms = 0;
      streak = 0;
      #1;
      chk("rst_VC0_rd", int'(bus.VC0_rd), 0);
      chk("rst_VC1_rd", int'(bus.VC1_rd), 0);
      chk("rst_valid",
          int'(bus.demux_dest_valid_in), 0);
      chk("rst_data", int'(bus.demux_dest_in), 0);
      chk("rst_state", int'(bus.state), 0);
      return;
    end
    if (g >= 0) begin
      e.cyc = cyc;
      e.d = (g == 0) ? q0[0] : q1[0];
      sb.push_back(e);
    end
    pend = g;
    if (ms < 2 || !v1 || g == 1) streak = 0;
    else if (g == 0 && streak < STARVE_MAX) streak++;
    if (!rst_n) ms = 0;
    else begin
      case (ms)
        0: ms = 1;
        1: ms = i_init ? 1 : 2;
        2: ms = i_init ? 1 : ((v0 || v1) ? 3 : 2);
        default: ms = i_init ? 1 : ((v0 || v1) ? 3 : 2);
      endcase
    end
  endtask

  initial begin : monitor
    bit  due;
    sb_t e;
    forever begin
      @(posedge clk);
      #4;
      due = sb.size() > 0 && sb[0].cyc == cyc - 1;
      chk("valid", int'(bus.demux_dest_valid_in),
          int'(due));
      if (due) begin
        e = sb.pop_front();
        chk("data", int'(bus.demux_dest_in), int'(e.d));
      end else begin
        chk("data_idle", int'(bus.demux_dest_in), 0);
      end
    end
  end

  initial begin
    reset_L = 1'b0;
    bus.init = 1'b0;
    bus.D0_almost_full = 1'b0;
    bus.D1_almost_full = 1'b0;
    bus.VC0_empty = 1'b1;
    bus.VC1_empty = 1'b1;
    bus.VC0_data_out = '0;
    bus.VC1_data_out = '0;

    repeat (3) step(0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0);

    q0.push_back(6'h15);
    repeat (4) step(1, 0, 0, 0, 0, 0);

    fill(12, 12);
    repeat (30) step(1, 0, 0, 0, 0, 0);

    fill(8, 8);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    repeat (5) step(1, 0, 0, 1, 0, 0);
    repeat (20) step(1, 0, 0, 0, 50, 0);

    fill(6, 6);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (15) step(1, 0, 0, 0, 0, 0);

    repeat (400)
      step(1, $urandom_range(49) == 0,
           $urandom_range(9) == 0,
           $urandom_range(9) == 0, 60, 0);

    repeat (20) step(1, 0, 0, 0, 0, 0);
    q0.delete();
    q1.delete();
    fill(0, 6);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    repeat (12) step(1, 0, 0, 0, 0, 0);

    @(posedge clk);
    #6;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vc_pop_arbiter.md
# vc_pop_arbiter

Pop scheduler for the virtual-channel stage. It sits between the VC0/VC1 FIFOs and the destination demux, and decides each cycle which VC FIFO, if any, is popped. VC0 has strict priority, with a starvation guard for VC1, and pops are blocked whenever a destination FIFO (D0/D1) is almost full. The popped word is registered and presented to the destination demux with a valid strobe.

## Interface
- `DATA_W`, default 6: FIFO word width. Bit `DATA_W-2` is the destination id (0 means D0, 1 means D1).
- `STARVE_MAX`, default 4: maximum consecutive VC0 grants while VC1 is non-empty, before VC1 is forced.
- `CNT_W`, default 3: starvation counter width. Must satisfy `2^CNT_W > STARVE_MAX`.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_L`  in  1  reset, asynchronous and active-low.
- `init`  in  1  synchronous re-initialise request.
- `VC0_empty`, `VC1_empty`  in  1 each  VC FIFO empty flags.
- `VC0_data_out`, `VC1_data_out`  in  DATA_W each  VC FIFO head words (first-word-fall-through, valid when not empty).
- `D0_almost_full`, `D1_almost_full`  in  1 each  destination FIFO almost-full flags.
- `VC0_rd`, `VC1_rd`  out  1 each  pop strobes, combinational from current state and inputs.
- `demux_dest_in`  out  DATA_W  registered popped word.
- `demux_dest_valid_in`  out  1  registered valid for `demux_dest_in`.
- `idle`  out  1  registered; 1 when the state is IDLE.
- `state`  out  2  FSM state: RESET=00, INIT=01, IDLE=10, ACTIVE=11.

## Operation
FSM transitions:
- RESET: entered asynchronously while `reset_L`=0. After release, go to INIT on the next edge.
- INIT: stay while `init`=1. When `init`=0, go to IDLE. The starvation counter is held at 0.
- IDLE: go to ACTIVE if either VC FIFO is non-empty, otherwise stay.
- ACTIVE: go to IDLE if both VC FIFOs are empty, otherwise stay.
- From IDLE or ACTIVE, `init`=1 sends the FSM to INIT on the next edge and blocks pops in that same cycle.

Pop enable:
- `go` = (state is IDLE or ACTIVE) and `init`=0 and not `D0_almost_full` and not `D1_almost_full`.

Grant, evaluated only when `go`=1:
- If VC1 is non-empty and `starve_cnt` ≥ `STARVE_MAX`: grant VC1.
- Else if VC0 is non-empty: grant VC0.
- Else if VC1 is non-empty: grant VC1.
- Otherwise no grant.
- At most one of `VC0_rd` / `VC1_rd` is high in any cycle.

Starvation counter (`starve_cnt`, CNT_W bits, internal):
- Increments on a VC0 grant while VC1 is non-empty, saturating at `STARVE_MAX`.
- Cleared on a VC1 grant, when VC1 is empty, or in INIT/RESET.
- Holds its value on cycles with no grant.

Output register, updated at each edge:
- On a grant: `demux_dest_valid_in` ← 1 and `demux_dest_in` ← the granted head word.
- With no grant: valid ← 0 and data ← 0.

## Timing
- Reset values: `demux_dest_in`=0, `demux_dest_valid_in`=0, `idle`=0, `state`=00, counter=0. `VC0_rd` and `VC1_rd` are forced to 0 while `reset_L`=0.
- Pop-to-valid latency: `rd` is high in cycle N, and `demux_dest_in`/valid are presented in cycle N+1 for exactly one cycle per pop.
- Almost-full is sampled combinationally. A pop is suppressed in the same cycle the flag rises, so data already registered still emerges the next cycle.
- With continuous traffic the block sustains one pop per cycle.
- `reset_L` falling mid-pop: `rd` drops immediately and the output register clears asynchronously. No pop is counted.
- First pop after reset is possible no earlier than the third edge after release (RESET→INIT, INIT→IDLE, then the grant).
- `idle` reflects the registered state, so it lags FIFO flags by one cycle.

## Test plan
- Reset/init: hold `reset_L`=0, release, keep `init`=1 for 3 cycles, then drop it. Required: state 00→01 (held 3 cycles)→10, no `rd` at any point, `idle`=1 in IDLE.
- Single pop: VC0 holds 0x15 (destination bit 4 = 1), VC1 empty. Required: `VC0_rd`=1 for 1 cycle, next cycle `demux_dest_in`=0x15 and valid=1, then state returns to IDLE.
- Priority and starvation with `STARVE_MAX`=4: both VC FIFOs full. Required grant sequence VC0,VC0,VC0,VC0,VC1,VC0×4,VC1…, with data order matching each FIFO's order.
- Backpressure: pop stream running, then `D1_almost_full`=1 for 5 cycles. Required: 0 `rd` during those 5 cycles, valid drops after 1 cycle, streaming resumes the cycle after the flag clears, and no word is lost or duplicated.
- Mid-stream `init`: assert `init`=1 during ACTIVE. Required: `rd`=0 in the same cycle, state=01 next, counter=0, and arbitration restarts with VC0 first.
- Async reset mid-pop: drop `reset_L` between edges while `VC1_rd`=1. Required: `rd`, valid and data go to 0 immediately, and state=00.
